gpio_debounce: RTL
==================

# gpio_debounce

Multi-channel glitch filter for GPIO input pins, generalising the fixed two-sample pin filter to a parametrised channel count and stability depth. Each channel is synchronised into `clk`, then accepted only after DEPTH consecutive enabled samples agree. It also reports rising and falling edges and rejected glitches as single-cycle pulses. It sits between the raw bus/GPIO pads and any logic that decodes strobes or data from them.

## Interface
- `WIDTH`, default 1: number of independent channels (1..64).
- `DEPTH`, default 2: consecutive enabled samples that must differ from the current output before it changes (2..16).
- `RESET_VAL`, default all-ones (`WIDTH` bits): value of synchroniser and output registers after reset.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  raw asynchronous pin inputs.
- `ena`  in  1  sample strobe; filter state advances only when high.
- `dout`  out  WIDTH  filtered, registered pin levels.
- `rise`  out  WIDTH  one-`clk` pulse when the channel's `dout` goes 0→1.
- `fall`  out  WIDTH  one-`clk` pulse when the channel's `dout` goes 1→0.
- `glitch`  out  WIDTH  one-`clk` pulse when a pending change is abandoned.
- `any_change`  out  1  OR of `rise|fall`, same cycle.

## Operation
- Synchroniser: two flops per channel, `s1<=din`, `s2<=s1`, every `clk`, independent of `ena`.
- Per-channel counter `cnt`, width `$clog2(DEPTH)`, counts differing samples.
- On a `clk` edge with `ena=1`, per channel:
  - If `s2==dout`: `cnt<=0`. If `cnt!=0`, pulse `glitch`.
  - Else if `cnt==DEPTH-1`: `dout<=s2`, `cnt<=0`, pulse `rise` or `fall` according to the new `s2`.
  - Else: `cnt<=cnt+1`.
- With `ena=0`: `cnt` and `dout` hold, and all pulse outputs are 0 on that edge.
- `rise`, `fall` and `glitch` are registered. Each is high for exactly one `clk` after the edge that produced it, even if `ena` stays high.
- Channels are fully independent; several channels may change on the same edge.
- `any_change` is registered, coincident with `rise`/`fall`.
- Reset values:
  - `s1`, `s2`, `dout`: `RESET_VAL`.
  - `cnt`: 0.
  - `rise`, `fall`, `glitch`, `any_change`: 0.
- Reset asserted mid-count discards the pending count with no pulse. After deassertion, filtering restarts from `RESET_VAL`.
- `cnt` never exceeds `DEPTH-1`; no wrap-around is possible.

## Timing
- Synchroniser latency: 2 `clk` from `din` to `s2`.
- Minimum `din`→`dout` latency with `ena` held high: 2 + DEPTH `clk` edges. Example: DEPTH=2 gives `dout` changing on the 4th edge after `din` settles before an edge.
- With a strobed `ena`: 2 `clk` of synchronisation, then DEPTH enabled edges.
- A pulse shorter than DEPTH enabled samples is rejected: `dout` is unchanged and `glitch` fires on the first enabled sample that returns to the `dout` level.
- Edge/glitch pulse appears in the same cycle that `dout` updates (edge) or that `cnt` clears (glitch).
- Reset release: the first enabled sample may be taken on the first `clk` edge after `reset` falls.

## Test plan
1. **Reset:** WIDTH=4, RESET_VAL=4'hF, assert `reset` asynchronously between edges → all outputs at reset values immediately; `dout=4'hF`, pulses 0.
2. **Clean fall:** WIDTH=1, DEPTH=2, `ena=1`, `din` 1→0 held → `dout` falls on the 4th edge; `fall=1` for exactly one cycle; `rise`, `glitch` stay 0.
3. **Glitch rejection:** DEPTH=4, `ena=1`, `din` low for 3 `clk` then high → `dout` stays 1; one `glitch` pulse when `s2` returns high; no `fall`.
4. **Strobed sampling:** DEPTH=3, `ena` high every 4th cycle, `din` 0→1 after reset to 0 → `rise` on the 3rd enabled edge after `s2` goes high; `cnt` holds between strobes.
5. **Multi-channel simultaneity:** WIDTH=8, DEPTH=2, `din` 8'hFF→8'h0F in one cycle → `dout=8'h0F` on the 4th edge; `fall=8'hF0`, `rise=0`, `any_change=1` for one cycle.
6. **Reset mid-count:** DEPTH=8, `din` low for 5 enabled samples, pulse `reset` → `cnt` cleared, `dout=RESET_VAL`, no `fall`/`glitch`; after release, a full 8 new samples are needed before `dout` falls.

Source files
------------

// File: rtl/gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
//
// Multi-channel glitch filter for raw GPIO / bus pins. Each channel is brought
// into the clk domain through a two-flop synchroniser. The synchronised level
// is then accepted as the new output only after DEPTH consecutive enabled
// samples disagree with the current output. Accepted edges are reported as
// single-cycle rise/fall pulses. An abandoned pending change is reported as a
// single-cycle glitch pulse.
//
// Parameters
//   WIDTH      number of independent channels (1..64)
//   DEPTH      consecutive differing enabled samples needed to change (2..16)
//   RESET_VAL  reset value of synchroniser and output registers
//
// Ports
//   clk         in   1      single clock, rising edge
//   reset       in   1      asynchronous, active-high reset
//   din         in   WIDTH  raw asynchronous pin levels
//   ena         in   1      sample strobe; filter state advances only when high
//   dout        out  WIDTH  filtered, registered pin levels
//   rise        out  WIDTH  one-cycle pulse when dout goes 0->1
//   fall        out  WIDTH  one-cycle pulse when dout goes 1->0
//   glitch      out  WIDTH  one-cycle pulse when a pending change is abandoned
//   any_change  out  1      OR of rise|fall, registered, coincident with them
// -----------------------------------------------------------------------------
module gpio_debounce #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             ena,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch,
  output logic             any_change
);

  localparam int unsigned     CNT_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchroniser stages; these run every clk regardless of ena.
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Filter state and registered event pulses.
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic [WIDTH-1:0] rise_q,   rise_d;
  logic [WIDTH-1:0] fall_q,   fall_d;
  logic [WIDTH-1:0] glitch_q, glitch_d;
  logic             any_q,    any_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state logic. The pulse outputs default to zero so that each pulse
  // lasts exactly one cycle and disabled edges produce no pulses at all.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    dout_d   = dout_q;
    rise_d   = '0;
    fall_d   = '0;
    glitch_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (ena) begin
        if (s2_q[i] == dout_q[i]) begin
          // Sample agrees with the output: any pending change is abandoned.
          cnt_d[i]    = '0;
          glitch_d[i] = (cnt_q[i] != '0);
        end else if (cnt_q[i] == CNT_MAX) begin
          // DEPTH-th consecutive differing sample: accept the new level.
          dout_d[i] = s2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= RESET_VAL;
      s2_q     <= RESET_VAL;
      dout_q   <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
      any_q    <= 1'b0;
      // NOTE: the counter array is reset explicitly; a reset mid-count must
      // discard the pending count, so it cannot be left as uninitialised
      // storage.
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep the s1 -> s2 shift a true
      // two-stage pipeline regardless of statement order.
      s1_q     <= din;
      s2_q     <= s1_q;
      dout_q   <= dout_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
      any_q    <= any_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dout       = dout_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch     = glitch_q;
  assign any_change = any_q;

endmodule
